// File: rtl/eth_10g_mac_stat_arbiter.sv
// eth_10g_mac_stat_arbiter
// Merges the TX and RX per-packet status streams into one Avalon-ST stream.
// The sources have no backpressure. Each source has a small FIFO, and the
// two FIFOs are served round-robin into a single output register.
// Optional feature macro: ETH_STAT_ARB_DROP_CNT_EN enables the saturating
// per-source drop counters. Without it, the counters read 0.

// Per-source FIFO. Pointers are one bit wider than the address so that
// full and empty come straight from a pointer compare.
module eth_stat_arb_fifo #(
  parameter int W     = 47,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         drop
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW:0]             wptr, rptr;
  logic                    full, push;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  // A full FIFO that pops in the same cycle frees a slot for the incoming word.
  assign push  = in_valid && (!full || pop);
  assign drop  = in_valid && !push;
  assign rdata = mem[rptr[AW-1:0]];

  // Pointer update. Both pointers wrap naturally at 2*DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage write. Contents are don't-care until the pointers cover them.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wdata;
  end
endmodule

module eth_10g_mac_stat_arbiter #(
  parameter int DATA_W     = 40,
  parameter int ERR_W      = 7,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [ERR_W-1:0]  tx_error,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic [ERR_W-1:0]  rx_error,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ERR_W-1:0]  out_error,
  output logic              out_channel,
  input  logic              cnt_clr,
  output logic [15:0]       tx_drop_cnt,
  output logic [15:0]       rx_drop_cnt
);
  localparam int NUM_SRC = 2;
  localparam int WORD_W  = DATA_W + ERR_W;

  // Index 0 = TX, 1 = RX. This matches the out_channel encoding.
  logic [NUM_SRC-1:0]             src_valid, src_empty, src_drop, pop;
  logic [NUM_SRC-1:0][WORD_W-1:0] src_word, src_head;
  logic                           load, any, sel, last_grant;

  assign src_valid = {rx_valid, tx_valid};
  assign src_word  = {{rx_data, rx_error}, {tx_data, tx_error}};

  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : g_src
      eth_stat_arb_fifo #(.W(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .in_valid (src_valid[g]),
        .wdata    (src_word[g]),
        .pop      (pop[g]),
        .rdata    (src_head[g]),
        .empty    (src_empty[g]),
        .drop     (src_drop[g])
      );
    end
  endgenerate

  // Arbitration. last_grant moves only on a tie, so a lone source never
  // steals the next tie from the other side.
  always_comb begin
    load = !out_valid || out_ready;
    pop  = '0;
    sel  = 1'b0;
    any  = 1'b0;
    if (load) begin
      if (!src_empty[0] && !src_empty[1]) begin
        sel = ~last_grant;
        any = 1'b1;
      end else if (!src_empty[0]) begin
        sel = 1'b0;
        any = 1'b1;
      end else if (!src_empty[1]) begin
        sel = 1'b1;
        any = 1'b1;
      end
      pop[sel] = any;
    end
  end

  // Round-robin state. Reset to RX so that TX wins the first tie.
  always_ff @(posedge clk) begin
    if (reset)
      last_grant <= 1'b1;
    else if (load && !src_empty[0] && !src_empty[1])
      last_grant <= sel;
  end

  // Output register. Holds while the downstream stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_error   <= '0;
      out_channel <= 1'b0;
    end else if (load) begin
      out_valid <= any;
      if (any) begin
        {out_data, out_error} <= src_head[sel];
        out_channel           <= sel;
      end
    end
  end

`ifdef ETH_STAT_ARB_DROP_CNT_EN
  logic [NUM_SRC-1:0][15:0] drop_cnt;

  generate
    for (g = 0; g < NUM_SRC; g++) begin : g_cnt
      // Saturating drop counter. Clear wins over a same-cycle increment.
      always_ff @(posedge clk) begin
        if (reset || cnt_clr)
          drop_cnt[g] <= '0;
        else if (src_drop[g] && drop_cnt[g] != 16'hFFFF)
          drop_cnt[g] <= drop_cnt[g] + 16'd1;
      end
    end
  endgenerate

  assign tx_drop_cnt = drop_cnt[0];
  assign rx_drop_cnt = drop_cnt[1];
`else
  logic unused_cnt_in;
  assign unused_cnt_in = ^{cnt_clr, src_drop};
  assign tx_drop_cnt   = '0;
  assign rx_drop_cnt   = '0;
`endif
endmodule
